clk_period_meter: RTL and testbench

CLK_PERIOD_METER -- requirements
Module: clk_period_meter

---
 rtl/clk_period_meter.sv | 98 +++++++++
 tb/tb_clk_period_meter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/clk_period_meter.sv
// Measures the period and high time of a slow asynchronous clock (measClk) in
// inClk cycles, and flags a stall when measClk stops toggling.
module clk_period_meter #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 65535
) (
    input  logic             inClk,
    input  logic             inRstn,
    input  logic             measClk,
    output logic [CNT_W-1:0] outPeriod,
    output logic [CNT_W-1:0] outHigh,
    output logic             outValid,
    output logic             outStall
);

    typedef enum logic [1:0] {
        ACQ   = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    state_t           state;
    logic             s1, s2, s3;
    logic [CNT_W-1:0] perCnt;
    logic [CNT_W-1:0] hiCnt;
    logic [CNT_W-1:0] hiHold;
    logic             rise, fall, timeoutHit;

    assign rise       = s2 & ~s3;
    assign fall       = ~s2 & s3;
    assign timeoutHit = (perCnt == TIMEOUT_C);

    always_ff @(posedge inClk) begin
        if (!inRstn) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            s3        <= 1'b0;
            perCnt    <= '0;
            hiCnt     <= '0;
            hiHold    <= '0;
            state     <= ACQ;
            outPeriod <= '0;
            outHigh   <= '0;
            outValid  <= 1'b0;
            outStall  <= 1'b0;
        end else begin
            s1       <= measClk;
            s2       <= s1;
            s3       <= s2;
            outValid <= 1'b0;

            // Counters restart on every rise; perCnt parks at TIMEOUT once stalled.
            if (rise) begin
                perCnt <= ONE_C;
                hiCnt  <= ONE_C;
            end else begin
                if (state != STALL && !timeoutHit)
                    perCnt <= perCnt + ONE_C;
                if (fall)
                    hiHold <= hiCnt;
                else if (s2)
                    hiCnt <= hiCnt + ONE_C;
            end

            case (state)
                ACQ: begin
                    if (rise) begin
                        state <= RUN;
                    end else if (timeoutHit) begin
                        state    <= STALL;
                        outStall <= 1'b1;
                    end
                end
                RUN: begin
                    if (rise) begin
                        outPeriod <= perCnt;
                        outHigh   <= hiHold;
                        outValid  <= 1'b1;
                        outStall  <= 1'b0;
                    end else if (timeoutHit) begin
                        state    <= STALL;
                        outStall <= 1'b1;
                    end
                end
                STALL: begin
                    // The first edge after a stall only restarts timing.
                    if (rise)
                        state <= RUN;
                end
                default: state <= ACQ;
            endcase
        end
    end

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: period/high measurement, stall timeout,
// recovery, mid-period reset and rise-coincident-with-timeout.
module tb_clk_period_meter;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 100;

    logic             inClk;
    logic             inRstn;
    logic             measClk;
    logic [CNT_W-1:0] outPeriod;
    logic [CNT_W-1:0] outHigh;
    logic             outValid;
    logic             outStall;

    clk_period_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .inClk    (inClk),
        .inRstn   (inRstn),
        .measClk  (measClk),
        .outPeriod(outPeriod),
        .outHigh  (outHigh),
        .outValid (outValid),
        .outStall (outStall)
    );

    initial inClk = 1'b0;
    always #5 inClk = ~inClk;

    int vecCnt  = 0;
    int missCnt = 0;

    // Output monitor, sampled on the falling edge away from the active edge.
    int          cycCnt       = 0;
    int          validCnt     = 0;
    int          lastValidCyc = 0;
    int          stallRiseCyc = -1;
    logic        prevStall    = 1'b0;
    int unsigned lastPer      = 0;
    int unsigned lastHigh     = 0;
    int unsigned lastStallAtV = 0;

    always @(negedge inClk) begin
        cycCnt = cycCnt + 1;
        if (outValid === 1'b1) begin
            validCnt     = validCnt + 1;
            lastValidCyc = cycCnt;
            lastPer      = outPeriod;
            lastHigh     = outHigh;
            lastStallAtV = outStall;
        end
        if (outStall === 1'b1 && prevStall !== 1'b1)
            stallRiseCyc = cycCnt;
        prevStall = outStall;
    end

    task automatic checkVal(input string tag, input int unsigned got, input int unsigned exp);
        vecCnt = vecCnt + 1;
        if (got !== exp) begin
            missCnt = missCnt + 1;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge inClk);
            #1;
        end
    endtask

    task automatic drive(input int hi, input int lo);
        measClk = 1'b1;
        cyc(hi);
        measClk = 1'b0;
        cyc(lo);
    endtask

    int vBase;

    initial begin
        inRstn  = 1'b0;
        measClk = 1'b0;
        cyc(3);
        checkVal("rst_period", outPeriod, 0);
        checkVal("rst_high",   outHigh,   0);
        checkVal("rst_valid",  outValid,  0);
        checkVal("rst_stall",  outStall,  0);

        // Period 8, 50% duty: first rise only arms, then one valid per rise.
        inRstn = 1'b1;
        cyc(2);
        drive(4, 4);
        checkVal("p8_first_rise_no_valid", validCnt, 0);
        repeat (3) drive(4, 4);
        checkVal("p8_valid_count", validCnt, 3);
        checkVal("p8_period", lastPer, 8);
        checkVal("p8_high",   lastHigh, 4);
        checkVal("p8_stall",  lastStallAtV, 0);

        // High 3 / low 7: first valid still closes an 8-cycle period.
        vBase = validCnt;
        drive(3, 7);
        checkVal("p10_transition_period", lastPer, 8);
        checkVal("p10_transition_high",   lastHigh, 4);
        drive(3, 7);
        drive(3, 7);
        checkVal("p10_valid_count", validCnt, vBase + 3);
        checkVal("p10_period", lastPer, 10);
        checkVal("p10_high",   lastHigh, 3);

        // Hold low: stall declared exactly TIMEOUT cycles after the last valid.
        vBase = validCnt;
        measClk = 1'b0;
        cyc(130);
        checkVal("stall_level", outStall, 1);
        checkVal("stall_delay", stallRiseCyc - lastValidCyc, TIMEOUT);
        checkVal("stall_period_hold", outPeriod, 10);
        checkVal("stall_high_hold",   outHigh, 3);
        checkVal("stall_no_valid", validCnt, vBase);

        // Recovery: first rise re-arms, second rise measures.
        drive(4, 4);
        checkVal("recov_first_no_valid", validCnt, vBase);
        checkVal("recov_stall_kept", outStall, 1);
        drive(4, 4);
        checkVal("recov_valid", validCnt, vBase + 1);
        checkVal("recov_period", lastPer, 8);
        checkVal("recov_stall_clear", outStall, 0);

        // One-cycle reset in the low phase discards the partial period.
        drive(4, 4);
        measClk = 1'b1;
        cyc(4);
        measClk = 1'b0;
        cyc(2);
        inRstn = 1'b0;
        cyc(1);
        checkVal("mrst_period", outPeriod, 0);
        checkVal("mrst_high",   outHigh,   0);
        checkVal("mrst_valid",  outValid,  0);
        checkVal("mrst_stall",  outStall,  0);
        inRstn = 1'b1;
        cyc(1);
        vBase = validCnt;
        drive(4, 4);
        checkVal("mrst_first_no_valid", validCnt, vBase);
        drive(4, 4);
        checkVal("mrst_second_valid", validCnt, vBase + 1);
        checkVal("mrst_period8", lastPer, 8);

        // Period equal to TIMEOUT: rise wins over timeout.
        vBase = validCnt;
        repeat (3) drive(TIMEOUT / 2, TIMEOUT / 2);
        checkVal("tmo_edge_valid_count", validCnt, vBase + 3);
        checkVal("tmo_edge_period", lastPer, TIMEOUT);
        checkVal("tmo_edge_high",   lastHigh, TIMEOUT / 2);
        checkVal("tmo_edge_stall",  outStall, 0);
        checkVal("tmo_edge_stall_at_valid", lastStallAtV, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
        $finish;
    end

endmodule
